lamp_monitor: RTL
=================

Name: lamp_monitor

Overview:
- Observes the two 5-bit lamp vectors that the intersection controller drives to the breadboard.
- Decodes them back into the controller phase (A–F) and times each phase in seconds.
- Flags illegal lamp patterns, out-of-order phase sequences and timing violations.
- Sits beside the controller on the GPIO path as a safety/self-check monitor; its outputs feed the HEX/LEDR status display.

Parameters:
STABLE_CYCLES, 1000, clocks a synchronized pattern must hold unchanged before it is accepted (glitch filter)
MIN_YELLOW, 2, minimum ticks a yellow phase (C or F) must last
MAX_PHASE, 30, maximum ticks any phase may last

Ports:
clock  in  1  system clock (CLOCK_50 domain)
resetn  in  1  asynchronous active-low reset
tick  in  1  one-cycle 1 Hz strobe, synchronous to clock
set1  in  5  lamp set 1: [4] T1 red, [3] T1 yellow, [2] T1 green, [1] P1 don't-walk, [0] P1 walk
set2  in  5  lamp set 2, same bit map for T2/P2
clear_fault  in  1  clears fault and fault_sticky
phase  out  3  decoded phase: 0=A … 5=F; 7=unknown
phase_valid  out  1  high while in TRACK
elapsed  out  8  ticks spent in current phase, saturating at 255
fault  out  3  first fault code since clear: 0 none, 1 illegal pattern, 2 illegal transition, 3 yellow short, 4 phase too long
fault_sticky  out  1  high while fault != 0
fault_valid  out  1  one-cycle pulse when a fault is detected

Behaviour:
- Reset (async, resetn=0): phase=7, phase_valid=0, elapsed=0, fault=0, fault_sticky=0, fault_valid=0. Synchronizer, filter and FSM are cleared; FSM enters ACQUIRE.
- Input path: {set1,set2} passes through a 2-flop synchronizer, then the stability filter.
  - The filter counter clears whenever the synchronized pattern changes.
  - On the clock where the counter reaches STABLE_CYCLES, the pattern is accepted.
  - Latency from pin change to phase update is 2+STABLE_CYCLES clocks.
  - A change shorter than STABLE_CYCLES is never accepted.
- Pattern decode, as (T1, T2, P1, P2):
  - A = (R, G, R, walk)
  - B = (R, G, R, flash)
  - C = (R, Y, R, R)
  - D = (G, R, walk, R)
  - E = (G, R, flash, R)
  - F = (Y, R, R, R)
  - Light codes: R=100, G=001, Y=010. Ped codes: walk=01, R=10, flash = [0]=0 with [1] either value.
  - In B and E, ped [1:0] of 00 or 10 both decode to the same phase, so flash toggling never causes a phase change.
  - Any other pattern is illegal, including two greens and multiple lamps lit in one head.
- FSM:
  - ACQUIRE:
    - Legal accepted pattern → TRACK; phase=decoded, elapsed=0; no transition check.
    - Illegal accepted pattern → fault 1, stay in ACQUIRE.
  - TRACK, newly accepted pattern:
    - Illegal → fault 1; phase=7; go to ACQUIRE.
    - Decoded phase not equal to (phase+1) mod 6 → fault 2; go to ACQUIRE.
    - Legal successor → phase updates and elapsed clears.
      - If leaving C or F with elapsed < MIN_YELLOW → fault 3, but TRACK continues with the new phase.
  - TRACK, on tick: elapsed increments, saturating at 255.
    - When elapsed becomes MAX_PHASE → fault 4, once per phase; stay in TRACK.
- phase_valid = (state == TRACK).
- Simultaneous events:
  - Tick on the same clock as an accepted phase change: clear wins, elapsed=0.
  - Several fault conditions on one clock: priority 1 > 2 > 3 > 4.
  - clear_fault on the same clock as a new fault: the new fault is latched.
  - fault latches only when fault==0 (first fault retained); fault_valid pulses for every detected fault.
- fault_sticky = (fault != 0). clear_fault does not change FSM state or phase.
- Reset asserted mid-operation: immediate return to reset values; re-acquisition requires a fresh stable pattern.

Decomposition:
- Package traffic_pkg holds:
  - phase encodings PH_A…PH_F, PH_UNKNOWN=7
  - fault codes FLT_*
  - lamp bit indices (RED=4, YEL=3, GRN=2, DONT=1, WALK=0)
  - light/ped code constants
- One sub-module, lamp_sync_filter: 2-flop synchronizer plus stability counter. It outputs a one-cycle accept strobe and the 10-bit accepted pattern.
- Decode, FSM and timers live in lamp_monitor.

Test Plan:
1. Legal cycle: A/B/C/D/E/F held 10/5/3/10/5/3 ticks, twice, with P flash toggling every 25M clocks → phase steps 0..5 and repeats; elapsed peaks at 10/5/3; fault stays 0.
2. set1=00101, set2=00110 (two greens) held stable, from TRACK → fault_valid pulse, fault=1, phase=7, phase_valid=0.
3. TRACK in A, then apply D pattern → fault=2, ACQUIRE; then clear_fault → fault=0; next stable E pattern → TRACK, phase=4.
4. C held for 1 tick, then D → phase=3, fault=3, phase_valid stays 1.
5. In A, change to B pattern for 500 clocks, then revert (STABLE_CYCLES=1000) → phase stays 0, elapsed keeps counting.
6. resetn pulsed low while elapsed=7 in D → all outputs at reset values immediately; D re-accepted 1002 clocks after release, elapsed=0.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared encodings for the intersection lamp monitor: phases, fault codes,
// lamp bit positions and the phase decoder.
package traffic_pkg;

  localparam logic [2:0] PH_A       = 3'd0;
  localparam logic [2:0] PH_B       = 3'd1;
  localparam logic [2:0] PH_C       = 3'd2;
  localparam logic [2:0] PH_D       = 3'd3;
  localparam logic [2:0] PH_E       = 3'd4;
  localparam logic [2:0] PH_F       = 3'd5;
  localparam logic [2:0] PH_UNKNOWN = 3'd7;

  localparam logic [2:0] FLT_NONE         = 3'd0;
  localparam logic [2:0] FLT_ILLEGAL      = 3'd1;
  localparam logic [2:0] FLT_TRANSITION   = 3'd2;
  localparam logic [2:0] FLT_YELLOW_SHORT = 3'd3;
  localparam logic [2:0] FLT_TOO_LONG     = 3'd4;

  localparam int unsigned RED  = 4;
  localparam int unsigned YEL  = 3;
  localparam int unsigned GRN  = 2;
  localparam int unsigned DONT = 1;
  localparam int unsigned WALK = 0;

  localparam logic [2:0] LIGHT_R  = 3'b100;
  localparam logic [2:0] LIGHT_G  = 3'b001;
  localparam logic [2:0] LIGHT_Y  = 3'b010;
  localparam logic [1:0] PED_WALK = 2'b01;
  localparam logic [1:0] PED_R    = 2'b10;

  typedef struct packed {
    logic [4:0] set1;
    logic [4:0] set2;
  } lamp_pattern_t;

  // Flashing ped heads only require the walk lamp off, so both flash states map to one phase.
  function automatic logic [2:0] decode_phase(input lamp_pattern_t p);
    logic [2:0] t1;
    logic [2:0] t2;
    logic [1:0] p1;
    logic [1:0] p2;
    logic       fl1;
    logic       fl2;
    t1  = p.set1[RED:GRN];
    t2  = p.set2[RED:GRN];
    p1  = p.set1[DONT:WALK];
    p2  = p.set2[DONT:WALK];
    fl1 = (p.set1[WALK] == 1'b0);
    fl2 = (p.set2[WALK] == 1'b0);
    if (t1 == LIGHT_R && t2 == LIGHT_G && p1 == PED_R && p2 == PED_WALK)
      decode_phase = PH_A;
    else if (t1 == LIGHT_R && t2 == LIGHT_G && p1 == PED_R && fl2)
      decode_phase = PH_B;
    else if (t1 == LIGHT_R && t2 == LIGHT_Y && p1 == PED_R && p2 == PED_R)
      decode_phase = PH_C;
    else if (t1 == LIGHT_G && t2 == LIGHT_R && p1 == PED_WALK && p2 == PED_R)
      decode_phase = PH_D;
    else if (t1 == LIGHT_G && t2 == LIGHT_R && fl1 && p2 == PED_R)
      decode_phase = PH_E;
    else if (t1 == LIGHT_Y && t2 == LIGHT_R && p1 == PED_R && p2 == PED_R)
      decode_phase = PH_F;
    else
      decode_phase = PH_UNKNOWN;
  endfunction

endpackage

// File: rtl/lamp_sync_filter.sv
// Two-flop synchronizer plus stability counter; strobes accept once per
// pattern that has held unchanged for STABLE_CYCLES clocks.
module lamp_sync_filter
  import traffic_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 1000
) (
  input  logic          clock,
  input  logic          resetn,
  input  lamp_pattern_t raw,
  output logic          accept,
  output lamp_pattern_t pattern
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  lamp_pattern_t meta;
  lamp_pattern_t sync;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic          chg;

  // cnt counts clocks the value entering sync has been seen there unchanged.
  always_comb begin
    chg   = (meta != sync);
    cnt_n = cnt;
    if (chg)
      cnt_n = CW'(1);
    else if (cnt != CNT_MAX)
      cnt_n = cnt + CW'(1);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      meta    <= '0;
      sync    <= '0;
      cnt     <= '0;
      accept  <= 1'b0;
      pattern <= '0;
    end else begin
      meta   <= raw;
      sync   <= meta;
      cnt    <= cnt_n;
      accept <= (cnt_n == CNT_MAX) && (chg || cnt != CNT_MAX);
      if ((cnt_n == CNT_MAX) && (chg || cnt != CNT_MAX))
        pattern <= meta;
    end
  end

endmodule

// File: rtl/lamp_monitor.sv
// Safety monitor: decodes filtered lamp patterns into controller phases,
// times each phase and latches the first sequencing/timing fault.
module lamp_monitor
  import traffic_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 1000,
  parameter int unsigned MIN_YELLOW    = 2,
  parameter int unsigned MAX_PHASE     = 30
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       tick,
  input  logic [4:0] set1,
  input  logic [4:0] set2,
  input  logic       clear_fault,
  output logic [2:0] phase,
  output logic       phase_valid,
  output logic [7:0] elapsed,
  output logic [2:0] fault,
  output logic       fault_sticky,
  output logic       fault_valid
);

  localparam logic [0:0] ST_ACQUIRE = 1'b0;
  localparam logic [0:0] ST_TRACK   = 1'b1;

  lamp_pattern_t raw;
  lamp_pattern_t pattern;
  logic          accept;
  logic [0:0]    state;
  logic [0:0]    state_n;
  logic [2:0]    phase_n;
  logic [7:0]    elapsed_n;
  logic [2:0]    det;
  logic [2:0]    fault_n;
  logic [2:0]    dec;
  logic [2:0]    succ;

  assign raw = '{set1: set1, set2: set2};

  lamp_sync_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_filter (
    .clock   (clock),
    .resetn  (resetn),
    .raw     (raw),
    .accept  (accept),
    .pattern (pattern)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      state <= ST_ACQUIRE;
    else
      state <= state_n;
  end

  // Re-accepting the current phase (flash toggle, rejected glitch) is not a transition.
  always_comb begin
    state_n   = state;
    phase_n   = phase;
    elapsed_n = elapsed;
    det       = FLT_NONE;
    dec       = decode_phase(pattern);
    succ      = (phase == PH_F) ? PH_A : 3'(phase + 3'd1);
    case (state)
      ST_ACQUIRE: begin
        if (accept) begin
          if (dec == PH_UNKNOWN) begin
            det = FLT_ILLEGAL;
          end else begin
            state_n   = ST_TRACK;
            phase_n   = dec;
            elapsed_n = 8'd0;
          end
        end
      end
      ST_TRACK: begin
        if (accept && dec != phase) begin
          if (dec == PH_UNKNOWN) begin
            det     = FLT_ILLEGAL;
            phase_n = PH_UNKNOWN;
            state_n = ST_ACQUIRE;
          end else if (dec != succ) begin
            det     = FLT_TRANSITION;
            state_n = ST_ACQUIRE;
          end else begin
            phase_n   = dec;
            elapsed_n = 8'd0;
            if ((phase == PH_C || phase == PH_F) && elapsed < 8'(MIN_YELLOW))
              det = FLT_YELLOW_SHORT;
          end
        end else if (tick && elapsed != 8'hFF) begin
          elapsed_n = elapsed + 8'd1;
          if (elapsed_n == 8'(MAX_PHASE))
            det = FLT_TOO_LONG;
        end
      end
      default: state_n = ST_ACQUIRE;
    endcase
  end

  // First fault since clear is retained; a clear on the detecting clock loses to the new fault.
  always_comb begin
    fault_n = fault;
    if (clear_fault)
      fault_n = FLT_NONE;
    if (det != FLT_NONE && (fault == FLT_NONE || clear_fault))
      fault_n = det;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      phase        <= PH_UNKNOWN;
      phase_valid  <= 1'b0;
      elapsed      <= 8'd0;
      fault        <= FLT_NONE;
      fault_sticky <= 1'b0;
      fault_valid  <= 1'b0;
    end else begin
      phase        <= phase_n;
      phase_valid  <= (state_n == ST_TRACK);
      elapsed      <= elapsed_n;
      fault        <= fault_n;
      fault_sticky <= (fault_n != FLT_NONE);
      fault_valid  <= (det != FLT_NONE);
    end
  end

endmodule
